// File: rtl/axi4_lite_reg_bank.sv
// Parametrised register bank: RW, read-only (HW_IN mirror) and W1C sticky registers,
// byte strobes, two-stage registered response. Define REG_BANK_WR_PULSE_EN to add WR_PULSE.
module axi4_lite_reg_bank #(
    parameter int unsigned                        ADDR_WIDTH   = 4,
    parameter int unsigned                        DATA_WIDTH   = 32,
    parameter int unsigned                        NUM_REGS     = 8,
    parameter logic [NUM_REGS-1:0]                RW_MASK      = '1,
    parameter logic [NUM_REGS-1:0]                W1C_MASK     = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]     RESET_VALUES = '0
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           REQ,
    input  logic                           WEN,
    input  logic [ADDR_WIDTH-1:0]          ADDR,
    input  logic [DATA_WIDTH-1:0]          W_DATA,
    input  logic [DATA_WIDTH/8-1:0]        W_STRB,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] HW_IN,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] HW_SET,
    output logic                           RSP_VALID,
    output logic [DATA_WIDTH-1:0]          R_DATA,
    output logic                           RSP_ERR,
`ifdef REG_BANK_WR_PULSE_EN
    output logic [NUM_REGS-1:0]            WR_PULSE,
`endif
    output logic [NUM_REGS*DATA_WIDTH-1:0] REG_OUT
);
    localparam int unsigned         STRB_W  = DATA_WIDTH / 8;
    localparam logic [NUM_REGS-1:0] SW_MASK = RW_MASK | W1C_MASK;

    logic [DATA_WIDTH-1:0]          byte_mask;
    logic [NUM_REGS-1:0]            hit;
    logic [NUM_REGS-1:0]            wr_ok;
    logic [NUM_REGS*DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0]          rd_data;
    logic [DATA_WIDTH-1:0]          resp_data;
    logic                           resp_err;

    logic                           p_valid;
    logic [DATA_WIDTH-1:0]          p_data;
    logic                           p_err;

    // Slices of HW_IN / HW_SET belonging to other register kinds are not consumed.
    logic unused_hw;
    assign unused_hw = ^{HW_IN, HW_SET};

    always_comb begin
        byte_mask = '0;
        for (int unsigned b = 0; b < STRB_W; b++)
            byte_mask[b*8 +: 8] = {8{W_STRB[b]}};
    end

    // Out-of-range addresses match no register, so hit doubles as the range check.
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            hit[i] = (ADDR == ADDR_WIDTH'(i));
    end

    assign wr_ok = (REQ && WEN && !RST) ? (hit & SW_MASK) : '0;

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            if (hit[i])
                rd_data = SW_MASK[i] ? cur[i*DATA_WIDTH +: DATA_WIDTH]
                                     : HW_IN[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign resp_err  = WEN ? ~|(hit & SW_MASK) : ~|hit;
    assign resp_data = WEN ? '0 : rd_data;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam logic [DATA_WIDTH-1:0] RV = RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
        if (W1C_MASK[i]) begin : g_w1c
            logic [DATA_WIDTH-1:0] q;
            // Clear first, then OR in the set pulses so a simultaneous set wins.
            always_ff @(posedge CLK) begin
                if (RST)
                    q <= RV;
                else
                    q <= (q & ~(wr_ok[i] ? (W_DATA & byte_mask) : '0))
                         | HW_SET[i*DATA_WIDTH +: DATA_WIDTH];
            end
            assign cur[i*DATA_WIDTH +: DATA_WIDTH] = q;
        end else if (RW_MASK[i]) begin : g_rw
            logic [DATA_WIDTH-1:0] q;
            always_ff @(posedge CLK) begin
                if (RST)
                    q <= RV;
                else if (wr_ok[i])
                    q <= (q & ~byte_mask) | (W_DATA & byte_mask);
            end
            assign cur[i*DATA_WIDTH +: DATA_WIDTH] = q;
        end else begin : g_ro
            assign cur[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
    end

    assign REG_OUT = cur;

    always_ff @(posedge CLK) begin
        if (RST) begin
            p_valid   <= 1'b0;
            p_data    <= '0;
            p_err     <= 1'b0;
            RSP_VALID <= 1'b0;
            R_DATA    <= '0;
            RSP_ERR   <= 1'b0;
        end else begin
            p_valid <= REQ;
            if (REQ) begin
                p_data <= resp_data;
                p_err  <= resp_err;
            end
            RSP_VALID <= p_valid;
            if (p_valid) begin
                R_DATA  <= p_data;
                RSP_ERR <= p_err;
            end
        end
    end

`ifdef REG_BANK_WR_PULSE_EN
    logic [NUM_REGS-1:0] p_wr;
    always_ff @(posedge CLK) begin
        if (RST) begin
            p_wr     <= '0;
            WR_PULSE <= '0;
        end else begin
            p_wr     <= wr_ok;
            WR_PULSE <= p_wr;
        end
    end
`endif

endmodule
